// File: rtl/uart_pkt_responder.sv
// Device-side UART packet responder: sync hunt, payload, checksum, ACK/NAK reply.
// Define UART_PKT_ECHO_EN to replay the payload after each ACK.
module uart_pkt_responder #(
    parameter int         PKT_LEN     = 9,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter logic [7:0] ACK_BYTE    = 8'h06,
    parameter logic [7:0] NAK_BYTE    = 8'h15,
    parameter int         TIMEOUT_CYC = 10_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_data_rdy,
    input  logic       i_frm_err,
    input  logic       i_transmission,
    output logic [7:0] o_tx_data,
    output logic       o_send_data,
    output logic [7:0] o_pld_data,
    output logic       o_pld_valid,
    output logic       o_pld_last,
    output logic       o_pkt_ok,
    output logic       o_pkt_err,
    output logic       o_overrun
);
    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC - 1);
    localparam logic [6:0]    CNT_CHK  = 7'(PKT_LEN - 1);
    localparam logic [6:0]    CNT_LAST = 7'(PKT_LEN - 2);

    typedef enum logic [2:0] {
        IDLE, RECV, CHECK, SEND, WAIT_BUSY, WAIT_DONE
`ifdef UART_PKT_ECHO_EN
        , ECHO
`endif
    } state_t;

    state_t        state, state_n;
    logic [6:0]    count;
    logic [7:0]    sum;
    logic          err;
    logic [TW-1:0] timer;
    logic          timeout;
    logic          timeout_err;
    logic          is_chk;
    logic          rx_busy;

    assign is_chk  = (count == CNT_CHK);
    assign rx_busy = (state != IDLE) && (state != RECV);

    // Combinational so the request lands two cycles after the checksum strobe.
    assign o_send_data = (state == SEND) && !i_transmission;
    assign o_pkt_ok    = (state == CHECK) && !err;
    assign o_pkt_err   = ((state == CHECK) && err) || timeout_err;

`ifdef UART_PKT_ECHO_EN
    localparam int IW = (PKT_LEN > 3) ? $clog2(PKT_LEN - 2) : 1;
    logic [7:0] pld_buf [2**IW];
    logic [6:0] echo_idx;

    always_ff @(posedge i_clk) begin
        if (state == RECV && i_rx_data_rdy && !is_chk)
            pld_buf[IW'(count - 7'd1)] <= i_rx_data;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_rx_data_rdy && !i_frm_err && i_rx_data == SYNC_BYTE)
                    state_n = RECV;
            end
            RECV: begin
                if (i_rx_data_rdy) begin
                    if (is_chk) state_n = CHECK;
                end else if (timer == TO_MAX) begin
                    state_n = IDLE;
                    timeout = 1'b1;
                end
            end
            CHECK:     state_n = SEND;
            SEND:      if (!i_transmission) state_n = WAIT_BUSY;
            WAIT_BUSY: if (i_transmission) state_n = WAIT_DONE;
            WAIT_DONE: begin
                if (!i_transmission) begin
`ifdef UART_PKT_ECHO_EN
                    state_n = (!err && echo_idx != CNT_LAST) ? ECHO : IDLE;
`else
                    state_n = IDLE;
`endif
                end
            end
`ifdef UART_PKT_ECHO_EN
            ECHO:      state_n = SEND;
`endif
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count       <= '0;
            sum         <= '0;
            err         <= 1'b0;
            timer       <= '0;
            o_tx_data   <= '0;
            o_pld_data  <= '0;
            o_pld_valid <= 1'b0;
            o_pld_last  <= 1'b0;
            o_overrun   <= 1'b0;
            timeout_err <= 1'b0;
`ifdef UART_PKT_ECHO_EN
            echo_idx    <= '0;
`endif
        end else begin
            o_pld_valid <= 1'b0;
            o_pld_last  <= 1'b0;
            o_overrun   <= i_rx_data_rdy && rx_busy;
            timeout_err <= timeout;
            unique case (state)
                IDLE: begin
                    if (state_n == RECV) begin
                        count <= 7'd1;
                        sum   <= '0;
                        err   <= 1'b0;
                        timer <= '0;
                    end
                end
                RECV: begin
                    if (i_rx_data_rdy) begin
                        timer <= '0;
                        count <= count + 7'd1;
                        err   <= err | i_frm_err | (is_chk && i_rx_data != sum);
                        if (!is_chk) begin
                            sum         <= sum + i_rx_data;
                            o_pld_data  <= i_rx_data;
                            o_pld_valid <= 1'b1;
                            o_pld_last  <= (count == CNT_LAST);
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CHECK: begin
                    o_tx_data <= err ? NAK_BYTE : ACK_BYTE;
`ifdef UART_PKT_ECHO_EN
                    echo_idx  <= '0;
`endif
                end
`ifdef UART_PKT_ECHO_EN
                ECHO: begin
                    o_tx_data <= pld_buf[IW'(echo_idx)];
                    echo_idx  <= echo_idx + 7'd1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_pkt_responder.sv
// Bench for uart_pkt_responder: packet table, scoreboard queues, tx handshake model.
// Also exercises garbage, timeout, overrun and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_uart_pkt_responder;
    localparam int PKT_LEN     = 9;
    localparam int NPLD        = PKT_LEN - 2;
    localparam int TIMEOUT_CYC = 10_000;
    localparam int TX_CYC      = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       frm_err = 1'b0;
    logic       transmission = 1'b0;
    logic [7:0] tx_data;
    logic       send_data;
    logic [7:0] pld_data;
    logic       pld_valid;
    logic       pld_last;
    logic       pkt_ok;
    logic       pkt_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_pkt_responder dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rx_data      (rx_data),
        .i_rx_data_rdy  (rx_rdy),
        .i_frm_err      (frm_err),
        .i_transmission (transmission),
        .o_tx_data      (tx_data),
        .o_send_data    (send_data),
        .o_pld_data     (pld_data),
        .o_pld_valid    (pld_valid),
        .o_pld_last     (pld_last),
        .o_pkt_ok       (pkt_ok),
        .o_pkt_err      (pkt_err),
        .o_overrun      (overrun)
    );

    typedef struct {
        logic [7:0] pld [NPLD];
        logic [7:0] chk;
        int         fe_pos;
        logic       ok;
    } vec_t;

    vec_t       tbl [8];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         strb_cyc = 0;
    int         res_cyc = -1;
    int         send_cyc = -1;
    logic [8:0] exp_pld_q [$];
    logic       exp_res_q [$];
    logic [7:0] exp_tx_q [$];
    int         exp_ovr_q [$];
    logic       tx_active = 1'b0;
    logic       tx_aborted = 1'b0;
    logic [7:0] tx_held = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h, expected no event (cycle %0d)", name, act, cyc);
    endtask

    // Scoreboard: every DUT event pops and compares an expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (pld_valid) begin
                if (exp_pld_q.size() == 0) unexpected("pld", 32'({pld_last, pld_data}));
                else check("pld", 32'({pld_last, pld_data}), 32'(exp_pld_q.pop_front()));
            end
            if (pkt_ok || pkt_err) begin
                if (res_cyc < 0) res_cyc = cyc;
                if (exp_res_q.size() == 0) unexpected("pkt_result", 32'({pkt_ok, pkt_err}));
                else begin
                    logic e;
                    e = exp_res_q.pop_front();
                    check("pkt_result", 32'({pkt_ok, pkt_err}), 32'({e, ~e}));
                end
            end
            if (send_data) begin
                if (send_cyc < 0) send_cyc = cyc;
                if (exp_tx_q.size() == 0) unexpected("tx_byte", 32'(tx_data));
                else check("tx_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
            end
            if (overrun) begin
                if (exp_ovr_q.size() == 0) unexpected("overrun", 32'(cyc));
                else check("overrun_cycle", 32'(cyc), 32'(exp_ovr_q.pop_front()));
            end
        end
    end

    // uart_tx stand-in: busy for TX_CYC cycles per request.
    initial begin
        forever begin
            @(negedge clk);
            if (send_data && !rst) begin
                tx_active  = 1'b1;
                tx_held    = tx_data;
                tx_aborted = 1'b0;
                @(posedge clk);
                #1 transmission = 1'b1;
                repeat (TX_CYC) begin
                    @(negedge clk);
                    if (rst) tx_aborted = 1'b1;
                end
                if (!tx_aborted) check("tx_hold", 32'(tx_data), 32'(tx_held));
                @(posedge clk);
                #1 transmission = 1'b0;
                tx_active = 1'b0;
            end
        end
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic fe);
        @(posedge clk);
        #1;
        rx_data  = b;
        frm_err  = fe;
        rx_rdy   = 1'b1;
        strb_cyc = cyc;
        @(posedge clk);
        #1;
        rx_rdy  = 1'b0;
        frm_err = 1'b0;
    endtask

    task automatic send_pkt(input vec_t v);
        for (int i = 0; i < NPLD; i++) exp_pld_q.push_back({1'(i == NPLD - 1), v.pld[i]});
        exp_res_q.push_back(v.ok);
        exp_tx_q.push_back(v.ok ? 8'h06 : 8'h15);
`ifdef UART_PKT_ECHO_EN
        if (v.ok) for (int i = 0; i < NPLD; i++) exp_tx_q.push_back(v.pld[i]);
`endif
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < NPLD; i++) send_byte(v.pld[i], v.fe_pos == i + 1);
        send_byte(v.chk, v.fe_pos == PKT_LEN - 1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_pld_q.size() != 0 || exp_res_q.size() != 0 || exp_tx_q.size() != 0 ||
                tx_active || transmission) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) unexpected("drain_timeout", 32'(exp_tx_q.size()));
        repeat (4) @(posedge clk);
    endtask

    task automatic run_vec(input int k);
        res_cyc  = -1;
        send_cyc = -1;
        send_pkt(tbl[k]);
        drain(3000);
        check("res_latency", 32'(res_cyc - strb_cyc), 32'd1);
        check("send_latency", 32'(send_cyc - strb_cyc), 32'd2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_send"}, 32'(send_data), 32'd0);
        check({tag, "_pld_data"}, 32'(pld_data), 32'd0);
        check({tag, "_pld_valid"}, 32'(pld_valid), 32'd0);
        check({tag, "_pld_last"}, 32'(pld_last), 32'd0);
        check({tag, "_pkt_ok"}, 32'(pkt_ok), 32'd0);
        check({tag, "_pkt_err"}, 32'(pkt_err), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    task automatic flush();
        exp_pld_q.delete();
        exp_res_q.delete();
        exp_tx_q.delete();
        exp_ovr_q.delete();
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!transmission && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) unexpected(name, 32'(n));
    endtask

    initial begin
        int t0;
        int n;
        tbl[0] = '{pld: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, chk: 8'h1C, fe_pos: -1, ok: 1'b1};
        tbl[1] = '{pld: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, chk: 8'h1D, fe_pos: -1, ok: 1'b0};
        tbl[2] = '{pld: '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}, chk: 8'h1C, fe_pos: 3, ok: 1'b0};
        tbl[3] = '{pld: '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70}, chk: 8'hC0, fe_pos: -1, ok: 1'b1};
        tbl[4] = '{pld: '{default: 8'hFF}, chk: 8'hF9, fe_pos: -1, ok: 1'b1};
        tbl[5] = '{pld: '{default: 8'hA5}, chk: 8'h83, fe_pos: -1, ok: 1'b1};
        tbl[6] = '{pld: '{default: 8'h00}, chk: 8'h00, fe_pos: 8, ok: 1'b0};
        tbl[7] = '{pld: '{default: 8'h00}, chk: 8'h01, fe_pos: -1, ok: 1'b0};

        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int k = 0; k < 8; k++) run_vec(k);

        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b1);
        repeat (3) @(posedge clk);
        run_vec(0);

        exp_pld_q.push_back({1'b0, 8'h01});
        exp_pld_q.push_back({1'b0, 8'h02});
        exp_res_q.push_back(1'b0);
        res_cyc = -1;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        t0 = strb_cyc;
        n = 0;
        while (exp_res_q.size() != 0 && n < TIMEOUT_CYC + 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= TIMEOUT_CYC + 100) unexpected("timeout_wait", 32'(n));
        check("timeout_window", 32'((res_cyc - t0 >= TIMEOUT_CYC) && (res_cyc - t0 <= TIMEOUT_CYC + 1)), 32'd1);
        repeat (4) @(posedge clk);
        run_vec(3);

        send_pkt(tbl[0]);
        wait_busy("overrun_busy_wait");
        send_byte(8'hA5, 1'b0);
        exp_ovr_q.push_back(strb_cyc + 1);
        send_byte(8'h01, 1'b0);
        exp_ovr_q.push_back(strb_cyc + 1);
        drain(3000);
        check("overrun_q_empty", 32'(exp_ovr_q.size()), 32'd0);
        run_vec(0);

        send_pkt(tbl[0]);
        wait_busy("rst_busy_wait");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero("rst_wait_done");
        flush();
        n = 0;
        while ((tx_active || transmission) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        run_vec(0);

        exp_pld_q.push_back({1'b0, 8'h01});
        exp_pld_q.push_back({1'b0, 8'h02});
        exp_pld_q.push_back({1'b0, 8'h03});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        #1 check("rst_recv_pre_valid", 32'(pld_valid), 32'd1);
        rst = 1'b1;
        #1 check_zero("rst_recv");
        flush();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        run_vec(0);

        check("end_pld_q", 32'(exp_pld_q.size()), 32'd0);
        check("end_tx_q", 32'(exp_tx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
